// File: rtl/pl_frame_scheduler_if.sv
// Symbol-scheduler handshake bundle: strobe/config inputs toward the scheduler, slot decisions back out.
// master drives the strobe and configuration; slave is the scheduler.
interface pl_frame_scheduler_if;
  logic        fs_en;
  logic        enable;
  logic [9:0]  cfg_slots;
  logic        cfg_pilot_on;
  logic        frame_ready;
  logic        data_rdy;
  logic        underrun_clr;
  logic        sym_strobe;
  logic [1:0]  sym_sel;
  logic [6:0]  sym_idx;
  logic [9:0]  slot_idx;
  logic        dummy;
  logic        frame_sof;
  logic        frame_eof;
  logic        data_rd;
  logic        underrun;
  logic [15:0] frame_cnt;

  modport master (
    output fs_en, enable, cfg_slots, cfg_pilot_on, frame_ready, data_rdy, underrun_clr,
    input  sym_strobe, sym_sel, sym_idx, slot_idx, dummy, frame_sof, frame_eof,
           data_rd, underrun, frame_cnt
  );

  modport slave (
    input  fs_en, enable, cfg_slots, cfg_pilot_on, frame_ready, data_rdy, underrun_clr,
    output sym_strobe, sym_sel, sym_idx, slot_idx, dummy, frame_sof, frame_eof,
           data_rd, underrun, frame_cnt
  );
endinterface

// File: rtl/pl_frame_scheduler.sv
// DVB-S2 PL-frame slot sequencer: each fs_en yields one registered symbol decision (1-cycle latency).
// Never stalls; a data pop with no upstream symbol only raises the sticky underrun flag.
module pl_frame_scheduler #(
  parameter int HDR_LEN         = 90,
  parameter int SLOT_LEN        = 90,
  parameter int PILOT_LEN       = 36,
  parameter int SLOTS_PER_PILOT = 16,
  parameter int DUMMY_SLOTS     = 36
) (
  input  logic                sys_clk,
  input  logic                glb_rst_n,
  pl_frame_scheduler_if.slave sif
);
  typedef enum logic [1:0] {
    SEG_IDLE  = 2'd0,
    SEG_HDR   = 2'd1,
    SEG_DATA  = 2'd2,
    SEG_PILOT = 2'd3
  } seg_e;

  localparam logic [6:0]  HDR_LAST     = 7'(HDR_LEN - 1);
  localparam logic [6:0]  SLOT_LAST    = 7'(SLOT_LEN - 1);
  localparam logic [6:0]  PILOT_LAST   = 7'(PILOT_LEN - 1);
  localparam logic [9:0]  DUMMY_LAST   = 10'(DUMMY_SLOTS - 1);
  localparam logic [10:0] PILOT_PERIOD = 11'(SLOTS_PER_PILOT);

  seg_e        seg_q, seg_d;
  logic [6:0]  sym_idx_q, sym_idx_d;
  logic [9:0]  slot_idx_q, slot_idx_d;
  logic [9:0]  slots_q, slots_d;
  logic        dummy_q, dummy_d;
  logic        pilot_on_q, pilot_on_d;
  logic        done_q, done_d;
  logic        strobe_q, strobe_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        rd_q, rd_d;
  logic        underrun_q, underrun_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [9:0]  last_slot;
  logic [10:0] slots_done;
  logic        pilot_due;

  // done_q marks that the last emitted symbol closed a frame, so the next strobe starts afresh.
  assign last_slot  = dummy_q ? DUMMY_LAST : slots_q - 10'd1;
  assign slots_done = {1'b0, slot_idx_q} + 11'd1;
  assign pilot_due  = pilot_on_q && !dummy_q && ((slots_done % PILOT_PERIOD) == 11'd0);

  always_comb begin
    seg_d       = seg_q;
    sym_idx_d   = sym_idx_q;
    slot_idx_d  = slot_idx_q;
    slots_d     = slots_q;
    dummy_d     = dummy_q;
    pilot_on_d  = pilot_on_q;
    done_d      = done_q;
    strobe_d    = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (sif.fs_en) begin
      strobe_d = 1'b1;
      if (seg_q == SEG_IDLE || done_q) begin
        done_d     = 1'b0;
        sym_idx_d  = 7'd0;
        slot_idx_d = 10'd0;
        if (sif.enable) begin
          seg_d      = SEG_HDR;
          sof_d      = 1'b1;
          slots_d    = sif.cfg_slots;
          pilot_on_d = sif.cfg_pilot_on;
          dummy_d    = !sif.frame_ready || (sif.cfg_slots == 10'd0);
        end else begin
          seg_d = SEG_IDLE;
        end
      end else begin
        unique case (seg_q)
          SEG_HDR: begin
            if (sym_idx_q == HDR_LAST) begin
              seg_d      = SEG_DATA;
              sym_idx_d  = 7'd0;
              slot_idx_d = 10'd0;
            end else begin
              sym_idx_d = sym_idx_q + 7'd1;
            end
          end
          SEG_DATA: begin
            if (sym_idx_q == SLOT_LAST) begin
              sym_idx_d = 7'd0;
              if (pilot_due) seg_d = SEG_PILOT;
              else           slot_idx_d = slot_idx_q + 10'd1;
            end else begin
              sym_idx_d = sym_idx_q + 7'd1;
            end
          end
          SEG_PILOT: begin
            if (sym_idx_q == PILOT_LAST) begin
              seg_d      = SEG_DATA;
              sym_idx_d  = 7'd0;
              slot_idx_d = slot_idx_q + 10'd1;
            end else begin
              sym_idx_d = sym_idx_q + 7'd1;
            end
          end
          default: ;
        endcase
        if (seg_d == SEG_DATA && sym_idx_d == SLOT_LAST && slot_idx_d == last_slot) begin
          eof_d       = 1'b1;
          done_d      = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
    end
    rd_d = strobe_d && (seg_d == SEG_DATA) && !dummy_d;
    // A fresh starvation in the same cycle as a clear must survive.
    if (rd_q && !sif.data_rdy) underrun_d = 1'b1;
    else if (sif.underrun_clr) underrun_d = 1'b0;
    else                       underrun_d = underrun_q;
  end

  always_ff @(posedge sys_clk or negedge glb_rst_n) begin
    if (!glb_rst_n) begin
      seg_q       <= SEG_IDLE;
      sym_idx_q   <= 7'd0;
      slot_idx_q  <= 10'd0;
      slots_q     <= 10'd0;
      dummy_q     <= 1'b0;
      pilot_on_q  <= 1'b0;
      done_q      <= 1'b0;
      strobe_q    <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      rd_q        <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      seg_q       <= seg_d;
      sym_idx_q   <= sym_idx_d;
      slot_idx_q  <= slot_idx_d;
      slots_q     <= slots_d;
      dummy_q     <= dummy_d;
      pilot_on_q  <= pilot_on_d;
      done_q      <= done_d;
      strobe_q    <= strobe_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      rd_q        <= rd_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sif.sym_strobe = strobe_q;
  assign sif.sym_sel    = seg_q;
  assign sif.sym_idx    = sym_idx_q;
  assign sif.slot_idx   = slot_idx_q;
  assign sif.dummy      = dummy_q;
  assign sif.frame_sof  = sof_q;
  assign sif.frame_eof  = eof_q;
  assign sif.data_rd    = rd_q;
  assign sif.underrun   = underrun_q;
  assign sif.frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_pl_frame_scheduler.sv
// Bench for pl_frame_scheduler: a positional frame-layout model feeds a scoreboard queue per strobe,
// a vector table checks whole-frame totals, and hand sequences cover underrun and async reset.
module tb_pl_frame_scheduler;
  localparam int HL  = 90;
  localparam int SL  = 90;
  localparam int PL  = 36;
  localparam int SPP = 16;
  localparam int DS  = 36;
  localparam int BLK = SPP * SL + PL;

  typedef struct packed {
    logic [1:0] sel;
    logic [6:0] idx;
    logic [9:0] slot;
    logic       dummy;
    logic       sof;
    logic       eof;
    logic       rd;
  } sym_t;

  typedef struct {
    int slots; int pilot; int ready; int gap;
    int exp_len; int exp_pil; int exp_rd; int exp_dummy;
  } vec_t;

  logic sys_clk = 1'b0;
  logic glb_rst_n;
  always #5 sys_clk = ~sys_clk;

  pl_frame_scheduler_if sif ();
  pl_frame_scheduler dut (.sys_clk(sys_clk), .glb_rst_n(glb_rst_n), .sif(sif));

  int checks = 0;
  int errors = 0;
  sym_t exp_q[$];

  // model state (main process only)
  int m_active = 0, m_pos = 0, m_len = 0, m_S = 0, m_P = 0, m_dummy = 0, m_frames = 0;
  // monitor counters (monitor process only)
  int n_fr = 0, n_sof = 0, n_eof = 0, n_rd = 0, n_pil = 0, last_dummy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic sym_t expect_sym(input int pos);
    sym_t e;
    int d, blk, r;
    e = '0;
    e.dummy = 1'(m_dummy);
    e.sof = (pos == 0);
    e.eof = (pos == m_len - 1);
    if (pos < HL) begin
      e.sel = 2'd1;
      e.idx = 7'(pos);
    end else begin
      d = pos - HL;
      if (m_P == 0) begin
        e.sel = 2'd2; e.idx = 7'(d % SL); e.slot = 10'(d / SL);
      end else begin
        blk = d / BLK;
        r   = d % BLK;
        if (r < SPP * SL) begin
          e.sel = 2'd2; e.idx = 7'(r % SL); e.slot = 10'(blk * SPP + r / SL);
        end else begin
          e.sel = 2'd3; e.idx = 7'(r - SPP * SL); e.slot = 10'(blk * SPP + SPP - 1);
        end
      end
    end
    e.rd = (e.sel == 2'd2) && (m_dummy == 0);
    return e;
  endfunction

  task automatic drive_strobe(input int gap, input bit rdy_low, input bit clr);
    sym_t e;
    if (m_active == 0 && sif.enable) begin
      m_active = 1;
      m_pos    = 0;
      m_dummy  = (!sif.frame_ready || sif.cfg_slots == 10'd0) ? 1 : 0;
      m_S      = m_dummy ? DS : int'(sif.cfg_slots);
      m_P      = (sif.cfg_pilot_on && m_dummy == 0) ? (m_S - 1) / SPP : 0;
      m_len    = HL + SL * m_S + PL * m_P;
    end
    if (m_active != 0) begin
      e = expect_sym(m_pos);
      m_pos++;
      if (m_pos == m_len) begin
        m_active = 0;
        m_frames++;
      end
    end else begin
      e = '0;
    end
    exp_q.push_back(e);
    sif.fs_en = 1'b1;
    @(posedge sys_clk); #1;
    sif.fs_en = 1'b0;
    sif.data_rdy = !rdy_low;
    sif.underrun_clr = clr;
    for (int i = 1; i < gap; i++) begin
      @(posedge sys_clk); #1;
      sif.data_rdy = 1'b1;
      sif.underrun_clr = 1'b0;
    end
    sif.data_rdy = 1'b1;
    sif.underrun_clr = 1'b0;
  endtask

  task automatic finish_frame(input int gap);
    for (int n = 0; n < 40000 && m_active != 0; n++) drive_strobe(gap, 1'b0, 1'b0);
    chk("frame_bound", 64'(m_active), 64'd0);
  endtask

  task automatic settle();
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({sif.sym_strobe, sif.sym_sel, sif.sym_idx, sif.slot_idx, sif.dummy, sif.frame_sof,
                sif.frame_eof, sif.data_rd, sif.underrun, sif.frame_cnt});
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    sym_t e, a;
    forever begin
      @(negedge sys_clk);
      chk("rd_gated", 64'(sif.data_rd & ~sif.sym_strobe), 64'd0);
      if (sif.sym_strobe) begin
        chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          a.sel = sif.sym_sel; a.idx = sif.sym_idx; a.slot = sif.slot_idx; a.dummy = sif.dummy;
          a.sof = sif.frame_sof; a.eof = sif.frame_eof; a.rd = sif.data_rd;
          if (e.sel == 2'd0) a.dummy = e.dummy;
          chk("sym", 64'(a), 64'(e));
          if (a.sel != 2'd0) n_fr++;
          if (a.sel == 2'd3) n_pil++;
          if (a.sof) begin n_sof++; last_dummy = int'(sif.dummy); end
          if (a.eof) n_eof++;
          if (a.rd)  n_rd++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t vec[6];
    int s_fr, s_sof, s_eof, s_rd, s_pil, f0;
    logic [15:0] fc0;
    vec[0] = '{360, 1, 1, 1, 33282, 22, 32400, 0};
    vec[1] = '{3,   0, 1, 3, 360,   0,  270,   0};
    vec[2] = '{3,   1, 0, 1, 3330,  0,  0,     1};
    vec[3] = '{16,  1, 1, 2, 1530,  0,  1440,  0};
    vec[4] = '{17,  1, 1, 2, 1656,  1,  1530,  0};
    vec[5] = '{0,   1, 1, 1, 3330,  0,  0,     1};

    glb_rst_n = 1'b0;
    sif.fs_en = 1'b0; sif.enable = 1'b0; sif.cfg_slots = 10'd0; sif.cfg_pilot_on = 1'b0;
    sif.frame_ready = 1'b0; sif.data_rdy = 1'b1; sif.underrun_clr = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    glb_rst_n = 1'b1;
    settle();
    chk("post_reset_outs", all_outs(), 64'd0);
    drive_strobe(2, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      sif.cfg_slots = 10'(vec[i].slots);
      sif.cfg_pilot_on = 1'(vec[i].pilot);
      sif.frame_ready = 1'(vec[i].ready);
      sif.enable = 1'b1;
      s_fr = n_fr; s_sof = n_sof; s_eof = n_eof; s_rd = n_rd; s_pil = n_pil;
      fc0 = sif.frame_cnt;
      drive_strobe(vec[i].gap, 1'b0, 1'b0);
      sif.enable = 1'b0;
      finish_frame(vec[i].gap);
      drive_strobe(vec[i].gap, 1'b0, 1'b0);
      settle();
      chk($sformatf("v%0d_len", i), 64'(n_fr - s_fr), 64'(vec[i].exp_len));
      chk($sformatf("v%0d_sof", i), 64'(n_sof - s_sof), 64'd1);
      chk($sformatf("v%0d_eof", i), 64'(n_eof - s_eof), 64'd1);
      chk($sformatf("v%0d_rd", i), 64'(n_rd - s_rd), 64'(vec[i].exp_rd));
      chk($sformatf("v%0d_pilot_syms", i), 64'(n_pil - s_pil), 64'(vec[i].exp_pil * PL));
      chk($sformatf("v%0d_dummy", i), 64'(last_dummy), 64'(vec[i].exp_dummy));
      chk($sformatf("v%0d_frame_cnt", i), 64'(sif.frame_cnt), 64'(fc0 + 16'd1));
    end

    // back-to-back frames while enable stays high
    sif.cfg_slots = 10'd3; sif.cfg_pilot_on = 1'b0; sif.frame_ready = 1'b1; sif.enable = 1'b1;
    s_fr = n_fr; s_sof = n_sof; fc0 = sif.frame_cnt; f0 = m_frames;
    for (int n = 0; n < 2000 && m_frames == f0; n++) drive_strobe(2, 1'b0, 1'b0);
    chk("b2b_bound", 64'(m_frames - f0), 64'd1);
    drive_strobe(2, 1'b0, 1'b0);
    sif.enable = 1'b0;
    finish_frame(2);
    drive_strobe(2, 1'b0, 1'b0);
    settle();
    chk("b2b_len", 64'(n_fr - s_fr), 64'd720);
    chk("b2b_sof", 64'(n_sof - s_sof), 64'd2);
    chk("b2b_frame_cnt", 64'(sif.frame_cnt), 64'(fc0 + 16'd2));

    // sticky underrun
    sif.enable = 1'b1;
    chk("urun_pre", 64'(sif.underrun), 64'd0);
    drive_strobe(2, 1'b0, 1'b0);
    sif.enable = 1'b0;
    for (int i = 1; i < HL; i++) drive_strobe(2, i == 5, 1'b0);
    chk("urun_hdr_starve", 64'(sif.underrun), 64'd0);
    drive_strobe(2, 1'b1, 1'b0);
    chk("urun_set", 64'(sif.underrun), 64'd1);
    repeat (3) drive_strobe(2, 1'b0, 1'b0);
    chk("urun_sticky", 64'(sif.underrun), 64'd1);
    drive_strobe(2, 1'b0, 1'b1);
    chk("urun_clr", 64'(sif.underrun), 64'd0);
    drive_strobe(2, 1'b1, 1'b1);
    chk("urun_set_wins", 64'(sif.underrun), 64'd1);
    finish_frame(2);
    drive_strobe(2, 1'b0, 1'b1);
    settle();
    chk("urun_final_clr", 64'(sif.underrun), 64'd0);

    // asynchronous reset in the middle of a pilot block
    sif.cfg_slots = 10'd20; sif.cfg_pilot_on = 1'b1; sif.frame_ready = 1'b1; sif.enable = 1'b1;
    drive_strobe(2, 1'b0, 1'b0);
    sif.enable = 1'b0;
    for (int n = 0; n < 3000 && m_pos < HL + SPP * SL + 10; n++) drive_strobe(2, 1'b0, 1'b0);
    chk("pilot_reached", 64'(m_pos), 64'(HL + SPP * SL + 10));
    #2;
    glb_rst_n = 1'b0;
    #1;
    chk("async_reset_outs", all_outs(), 64'd0);
    chk("sb_drained_at_reset", 64'(exp_q.size()), 64'd0);
    m_active = 0;
    m_pos = 0;
    @(posedge sys_clk); #1;
    glb_rst_n = 1'b1;
    sif.cfg_slots = 10'd3; sif.cfg_pilot_on = 1'b0; sif.enable = 1'b1;
    s_sof = n_sof;
    drive_strobe(2, 1'b0, 1'b0);
    sif.enable = 1'b0;
    finish_frame(2);
    drive_strobe(2, 1'b0, 1'b0);
    settle();
    chk("restart_sof", 64'(n_sof - s_sof), 64'd1);
    chk("restart_frame_cnt", 64'(sif.frame_cnt), 64'd1);

    settle();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pl_frame_scheduler.md
Name: pl_frame_scheduler

Overview:
Sequences DVB-S2 PL-frame symbol slots from the fractional-rate symbol strobe produced by the baud-enable generator. Each fs_en pulse is one output symbol. The block decides whether that symbol is PLHEADER, data-slot, pilot-block or idle, and requests data symbols from the upstream mapper FIFO. If no payload frame is ready at a frame boundary, it inserts a DVB-S2 dummy PLFRAME (header plus 36 unmodulated slots, no pilots).

Parameters:
HDR_LEN, 90, PLHEADER length in symbols
SLOT_LEN, 90, symbols per data slot
PILOT_LEN, 36, symbols per pilot block
SLOTS_PER_PILOT, 16, data slots between pilot blocks
DUMMY_SLOTS, 36, slots in a dummy PLFRAME

Ports:
sys_clk  in  1  system clock
glb_rst_n  in  1  asynchronous active-low reset
fs_en  in  1  single-cycle symbol-rate strobe
enable  in  1  run request; sampled at frame boundaries
cfg_slots  in  10  data slots per payload frame (1..1023); 0 = force dummy frame
cfg_pilot_on  in  1  insert pilot blocks in payload frames
frame_ready  in  1  upstream holds at least one full payload frame
data_rdy  in  1  upstream data symbol available this cycle
underrun_clr  in  1  clears the sticky underrun flag
sym_strobe  out  1  registered copy of fs_en while active
sym_sel  out  2  0 idle, 1 header, 2 data, 3 pilot
sym_idx  out  7  symbol index within the current segment
slot_idx  out  10  data slot index within the frame
dummy  out  1  current frame is a dummy frame
frame_sof  out  1  with first header symbol
frame_eof  out  1  with last symbol of frame
data_rd  out  1  pop one data symbol from upstream
underrun  out  1  sticky flag: data_rd issued while data_rdy=0
frame_cnt  out  16  completed frames, wraps at 65535 to 0

Behaviour:
- Reset, asynchronous and active-low on glb_rst_n: state IDLE; all outputs 0; latched configuration 0. Reset asserted mid-frame aborts the frame immediately with no eof.
- Latency: all outputs are registered and appear 1 cycle after the sys_clk edge where fs_en=1. Outputs are only meaningful when sym_strobe=1. sym_strobe is a 1-cycle pulse.
- States:
  - IDLE -> HDR: on fs_en while enable=1. That strobe emits header symbol 0 with frame_sof=1.
  - HDR -> DATA: after HDR_LEN symbols.
  - DATA -> PILOT: at the end of a slot when pilots are on, the frame is not a dummy, the completed slot count is a multiple of 16, and it is not the last slot.
  - PILOT -> DATA: after PILOT_LEN symbols.
  - DATA -> end of frame: at the end of the last slot.
- Frame start latch: at the first header symbol, cfg_slots and cfg_pilot_on are latched. dummy is set to (frame_ready==0 || cfg_slots==0), and stays constant for the whole frame.
- Slot counts: a payload frame carries latched cfg_slots slots; a dummy frame carries DUMMY_SLOTS slots. Pilot blocks per payload frame = floor((S-1)/16).
- End of frame: the last data symbol carries frame_eof=1, and frame_cnt increments in the same cycle.
  - Next fs_en with enable=1: go directly to HDR (back-to-back frames, no gap).
  - Next fs_en with enable=0: go to IDLE, with sym_strobe=1 and sym_sel=0.
  - enable deasserted mid-frame has no effect until the frame ends.
- In IDLE, fs_en still produces sym_strobe with sym_sel=0. sym_idx and slot_idx hold 0.
- sym_idx counts 0..segment_len-1 and resets at each segment change. slot_idx counts 0..S-1 and holds its value during pilot blocks.
- data_rd = sym_strobe && sym_sel==2 && !dummy.
- underrun is set when data_rd=1 and data_rdy=0 in the same cycle. The scheduler does not stall; the frame continues.
- underrun_clr clears underrun. If clear and a new set occur in the same cycle, set wins.
- fs_en is assumed to be at most one pulse per 2 cycles. Back-to-back fs_en pulses must still each advance exactly one symbol.

Test Plan:
1. Reset release, enable=1, frame_ready=1, cfg_slots=360, pilot on, fs_en every 4 cycles -> 90 header, 22 pilot blocks (first pilot starts at data symbol 1440), frame length 33282 strobes, one sof, one eof, data_rd count 32400, frame_cnt=1.
2. Same with pilot off, cfg_slots=3 -> sequence 90 H, 270 D, eof on strobe 360, then header of next frame immediately.
3. frame_ready=0 at frame start -> dummy=1, 90 H + 3240 D, data_rd never asserted, no pilots even with pilot on.
4. Drop enable mid-frame -> frame completes, next strobes sym_sel=0; re-assert -> sof on next fs_en.
5. data_rdy=0 for one data symbol -> underrun=1 sticky; assert underrun_clr with no new underrun -> 0; clear and set in the same cycle -> stays 1.
6. Assert glb_rst_n low mid-pilot, asynchronously between clock edges -> outputs 0 immediately; after release, restart from header symbol 0.
